// File: rtl/jk_bank_sequencer.sv
// Bank of four J-K cells stepped from debounced buttons or an auto-run tick.
// Switch inputs select the J/K command and the target cell; LEDs show q, ~q and status.
`timescale 1ns/1ps

module jk_bank_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned AUTO_DIV        = 50000000,
    parameter int unsigned N_CELLS         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw_pin,
    input  logic        btn_1,
    input  logic        btn_2,
    output logic [15:0] led_pin
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TICK_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_DIV - 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    logic [1:0]         btn_meta_r;
    logic [1:0]         btn_sync_r;
    logic [4:0]         sw_meta_r;
    logic [4:0]         sw_sync_r;
    logic [DB_W-1:0]    db_cnt_r [2];
    logic [1:0]         btn_acc_r;
    logic [1:0]         btn_acc_d_r;
    logic [1:0]         btn_pulse_r;
    state_t             state_r;
    state_t             state_next_s;
    logic [TICK_W-1:0]  tick_r;
    logic [TICK_W-1:0]  tick_next_s;
    logic [1:0]         ptr_r;
    logic [1:0]         ptr_next_s;
    logic [N_CELLS-1:0] q_r;
    logic [N_CELLS-1:0] q_next_s;
    logic [N_CELLS-1:0] mask_s;
    logic [4:0]         cnt_r;
    logic [4:0]         cnt_next_s;
    logic               step_s;
    logic               step_p_s;
    logic               mode_p_s;
    logic [15:0]        led_r;
    logic               unused_s;

    // One-hot target mask, or every cell when broadcasting.
    function automatic logic [N_CELLS-1:0] cell_mask(input logic all_cells, input logic [1:0] sel);
        logic [N_CELLS-1:0] m;
        if (all_cells) begin
            m = '1;
        end else begin
            m = '0;
            m[sel] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        case (jk)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    assign unused_s = ^sw_pin[7:5];
    assign step_p_s = btn_pulse_r[0];
    assign mode_p_s = btn_pulse_r[1];
    assign led_pin  = led_r;

    // Two-flop synchronisers for the buttons and the used switch bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
            sw_meta_r  <= 5'b00000;
            sw_sync_r  <= 5'b00000;
        end else begin
            btn_meta_r <= {btn_2, btn_1};
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_pin[4:0];
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debounce: a level is accepted only after it differs from the accepted one for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= '0;
            end
            btn_acc_r   <= 2'b00;
            btn_acc_d_r <= 2'b00;
            btn_pulse_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] == btn_acc_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_cnt_r[i]  <= '0;
                    btn_acc_r[i] <= btn_sync_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
            btn_acc_d_r <= btn_acc_r;
            btn_pulse_r <= btn_acc_r & ~btn_acc_d_r;
        end
    end

    // Mode FSM, auto tick and step decision; a step always uses the mode held before a toggle.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        ptr_next_s   = ptr_r;
        step_s       = 1'b0;
        mask_s       = '0;
        case (state_r)
            ST_MANUAL: begin
                tick_next_s = '0;
                if (step_p_s) begin
                    step_s = 1'b1;
                    mask_s = cell_mask(sw_sync_r[4], sw_sync_r[3:2]);
                end else begin
                    step_s = 1'b0;
                end
                if (mode_p_s) begin
                    state_next_s = ST_AUTO;
                end else begin
                    state_next_s = ST_MANUAL;
                end
            end
            ST_AUTO: begin
                if (tick_r == TICK_LAST) begin
                    step_s      = 1'b1;
                    tick_next_s = '0;
                    mask_s      = cell_mask(sw_sync_r[4], ptr_r);
                    ptr_next_s  = ptr_r + 2'd1;
                end else begin
                    tick_next_s = tick_r + TICK_W'(1);
                end
                if (mode_p_s) begin
                    state_next_s = ST_MANUAL;
                    tick_next_s  = '0;
                end else begin
                    state_next_s = ST_AUTO;
                end
            end
            default: begin
                state_next_s = ST_MANUAL;
                tick_next_s  = '0;
            end
        endcase
    end

    // Per-cell J-K update and step counter.
    always_comb begin
        q_next_s = q_r;
        for (int i = 0; i < N_CELLS; i++) begin
            if (step_s && mask_s[i]) begin
                q_next_s[i] = jk_next(q_r[i], sw_sync_r[1:0]);
            end else begin
                q_next_s[i] = q_r[i];
            end
        end
        if (step_s) begin
            cnt_next_s = cnt_r + 5'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State registers; LEDs are loaded from next-state values so they track the bank without lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_MANUAL;
            tick_r  <= '0;
            ptr_r   <= 2'd0;
            q_r     <= '0;
            cnt_r   <= 5'd0;
            led_r   <= 16'h00F0;
        end else begin
            state_r <= state_next_s;
            tick_r  <= tick_next_s;
            ptr_r   <= ptr_next_s;
            q_r     <= q_next_s;
            cnt_r   <= cnt_next_s;
            led_r   <= {cnt_next_s, ptr_next_s, (state_next_s == ST_AUTO), ~q_next_s, q_next_s};
        end
    end

endmodule
